alu_op_issuer: RTL and testbench

//  Sequential front end that drives the combinational 4-bit ALU (add/sub/and/or) and collects its results.

---
 rtl/alu_op_issuer.sv | 136 +++++++++++++
 tb/tb_alu_op_issuer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Buffers ALU requests in a DEPTH-entry FIFO, issues one at a time on registered operand lines, returns results in order.
// Latency: accept at E0 -> out_valid after E2 on an idle, empty path; one result per 2 cycles at full rate.
// Backpressure: in_ready drops when the FIFO is full; out_* hold while out_ready is low. Optional ALU_CHECK_EN adds a result checker.
module alu_op_issuer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [1:0]       in_sel,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             chk_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       sel;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    req_t          mem [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          has_req;
    logic          push;
    logic          pop;
    state_t        state;

    // in_ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign in_ready = (count != FULL_CNT);
    assign has_req  = (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = has_req && ((state == IDLE) || (state == HOLD && out_ready));
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_A, b: in_B, sel: in_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_sel    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
        end else begin
            if (pop) begin
                alu_A   <= head.a;
                alu_B   <= head.b;
                alu_sel <= head.sel;
            end
            case (state)
                IDLE: begin
                    if (has_req) state <= ISSUE;
                end
                ISSUE: begin
                    out_result <= alu_result;
                    out_zero   <= (alu_result == '0);
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= has_req ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_CHECK_EN
    logic [WIDTH-1:0] ref_result;

    always_comb begin
        ref_result = '0;
        case (alu_sel)
            2'd0:    ref_result = alu_A + alu_B;
            2'd1:    ref_result = alu_A - alu_B;
            2'd2:    ref_result = alu_A & alu_B;
            default: ref_result = alu_A | alu_B;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (state == ISSUE && ref_result != alu_result) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed + random bench for alu_op_issuer with a zero-delay behavioural ALU stub and an in-order scoreboard.
module tb_alu_op_issuer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_A, in_B;
    logic [1:0] in_sel;
    logic [3:0] alu_A, alu_B;
    logic [1:0] alu_sel;
    logic [3:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_zero;
    logic       chk_err;
    bit         stub_bad;

    int         total = 0;
    int         bad = 0;
    logic [3:0] exp_q [$];

`ifdef ALU_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_op_issuer #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_sel(in_sel),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .chk_err(chk_err)
    );

    // ALU stub; stub_bad makes subtract behave as add to exercise the checker.
    always_comb begin
        case (alu_sel)
            2'd0:    alu_result = alu_A + alu_B;
            2'd1:    alu_result = stub_bad ? alu_A + alu_B : alu_A - alu_B;
            2'd2:    alu_result = alu_A & alu_B;
            default: alu_result = alu_A | alu_B;
        endcase
    end

    function automatic logic [3:0] model(int a, int b, int s, bit badalu);
        int r;
        case (s)
            0:       r = a + b;
            1:       r = badalu ? a + b : a - b + 16;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return 4'(r % 16);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes seen before the edge, then advance to 1 time unit past it.
    task automatic tick();
        bit acc, dlv;
        logic [3:0] e;
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        if (dlv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", out_result, e);
                check("zero", out_zero, (e == 4'h0));
            end
        end
        if (acc) exp_q.push_back(model(in_A, in_B, in_sel, stub_bad));
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [3:0] a, logic [3:0] b, logic [1:0] s);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_A = a; in_B = b; in_sel = s;
        for (int i = 0; i < 50; i++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 1, 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            if (out_valid) return;
            tick();
        end
        check("wait_valid_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; in_sel = '0;
        out_ready = 1'b0; stub_bad = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_chk_err", chk_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Add with latency check
        out_ready = 1'b1;
        in_valid = 1'b1; in_A = 4'd7; in_B = 4'd5; in_sel = 2'd0;
        check("add_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("lat_e0", out_valid, 0);
        tick();
        check("lat_e1", out_valid, 0);
        tick();
        check("lat_e2", out_valid, 1);
        check("add_result", out_result, 4'hC);
        check("add_zero", out_zero, 0);
        tick();

        // Subtract, including a zero result
        send(4'd3, 4'd5, 2'd1);
        send(4'd5, 4'd5, 2'd1);
        wait_valid();
        check("sub_neg", out_result, 4'hE);
        tick();
        wait_valid();
        check("sub_zero_val", out_result, 4'h0);
        check("sub_zero_flag", out_zero, 1);
        drain();

        // Backpressure and full FIFO
        out_ready = 1'b0;
        send(4'hC, 4'hA, 2'd2);
        send(4'hC, 4'hA, 2'd3);
        for (int i = 0; i < 3; i++) send(4'($urandom), 4'($urandom), 2'($urandom));
        in_valid = 1'b1; in_A = 4'h1; in_B = 4'h1; in_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            check("full_in_ready", in_ready, 0);
            check("full_held_valid", out_valid, 1);
            check("full_held_result", out_result, 4'h8);
            tick();
        end
        in_valid = 1'b0;
        check("full_accepted", exp_q.size(), 5);
        out_ready = 1'b1;
        tick();
        wait_valid();
        check("or_result", out_result, 4'hE);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_A = 4'($urandom); in_B = 4'($urandom); in_sel = 2'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset mid-run is asynchronous
        out_ready = 1'b0;
        send(4'h9, 4'h4, 2'd0);
        send(4'h2, 4'h3, 2'd3);
        wait_valid();
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_alu_sel", alu_sel, 0);
        check("arst_out_result", out_result, 0);
        check("arst_chk_err", chk_err, 0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset with requests queued and one in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'($urandom), 4'($urandom), 2'($urandom));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("no_ghost_results", seen, 0);

        // Faulty ALU stub and sticky checker
        stub_bad = 1'b1;
        send(4'd6, 4'd2, 2'd1);
        wait_valid();
        check("badalu_result", out_result, 4'h8);
        tick();
        check("chk_err_set", chk_err, CHK);
        stub_bad = 1'b0;
        send(4'd1, 4'd2, 2'd0);
        send(4'd9, 4'd9, 2'd1);
        drain();
        check("chk_err_sticky", chk_err, CHK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
